// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A shadow register set is written by the host at any time; it is copied into
// the active set only at the start of a frame so that a frame never tears.
//
// state | meaning
// ------+------------------------------------------------------------------
// FETCH | one cycle; at idx 0 the active set copies the shadow set
// ON    | REFRESH_DIV cycles; digit idx is lit if enabled
// BLANK | BLANK_CYCLES cycles; all digits dark to avoid ghosting
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  enable,
  input  logic        load,
  output logic [7:0]  display,
  output logic [7:0]  Anode,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // 20 bits covers the largest legal count (2^20 - 1) for either phase.
  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] sh_digits_q, sh_digits_d;
  logic [7:0]  sh_dp_q, sh_dp_d;
  logic [7:0]  sh_en_q, sh_en_d;
  logic [31:0] act_digits_q, act_digits_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_en_q, act_en_d;

  logic [7:0] anode_q, anode_d;
  logic [7:0] display_q, display_d;
  logic       frame_done_q, frame_done_d;

  // Active-low hex decode, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state logic: scan sequencing, shadow capture, frame-start copy.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_ON;
        cnt_d   = '0;
        // Copy uses the shadow as it was before this edge, so a load in the
        // same cycle lands in the following frame.
        if (idx_q == 3'd0) begin
          act_digits_d = sh_digits_q;
          act_dp_d     = sh_dp_q;
          act_en_d     = sh_en_q;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_FETCH;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase

    if (load) begin
      sh_digits_d = digits;
      sh_dp_d     = dp_in;
      sh_en_d     = enable;
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // exactly with the state they describe.
  always_comb begin
    anode_d      = 8'hFF;
    display_d    = 8'hFF;
    frame_done_d = (state_d == S_BLANK) && (idx_d == 3'd7) && (cnt_d == BLANK_LAST);
    if ((state_d == S_ON) && act_en_d[idx_d]) begin
      anode_d[idx_d] = 1'b0;
      display_d      = {~act_dp_d[idx_d], seg7(act_digits_d[{idx_d, 2'b00} +: 4])};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      anode_q      <= 8'hFF;
      display_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      anode_q      <= anode_d;
      display_q    <= display_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Anode      = anode_q;
  assign display    = display_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with a short refresh setting.
module tb_seven_seg_scanner;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = 1 + R + B;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  enable = '0;
  logic        load = 1'b0;
  logic [7:0]  display;
  logic [7:0]  Anode;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  seven_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in),
    .enable(enable), .load(load), .display(display), .Anode(Anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  // Behavioural model: cycle index since reset plus shadow/active sets.
  int          m_k = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_sh_d = '0, m_act_d = '0;
  logic [7:0]  m_sh_p = '0, m_act_p = '0, m_sh_e = '0, m_act_e = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_k     <= 0;
      m_sh_d  <= '0; m_sh_p  <= '0; m_sh_e  <= '0;
      m_act_d <= '0; m_act_p <= '0; m_act_e <= '0;
    end else if (m_valid) begin
      if (m_k % FRAME == 0) begin
        m_act_d <= m_sh_d; m_act_p <= m_sh_p; m_act_e <= m_sh_e;
      end
      if (load) begin
        m_sh_d <= digits; m_sh_p <= dp_in; m_sh_e <= enable;
      end
      m_k <= m_k + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp_p
    int pos, idx;
    logic on;
    logic [7:0] e_an, e_dis;
    logic [3:0] dig;
    if (m_valid) begin
      pos   = m_k % SLOT;
      idx   = (m_k / SLOT) % 8;
      on    = (pos >= 1) && (pos <= R) && m_act_e[idx];
      dig   = 4'((m_act_d >> (4 * idx)) & 32'hF);
      e_an  = on ? ~(8'h01 << idx) : 8'hFF;
      e_dis = on ? {~m_act_p[idx], hex_seg(dig)} : 8'hFF;
      chk("model_anode", {24'h0, Anode}, {24'h0, e_an});
      chk("model_display", {24'h0, display}, {24'h0, e_dis});
      chk("model_frame_done", {31'h0, frame_done}, {31'h0, (m_k % FRAME) == FRAME - 1});
      chk("anode_onehot", ($countones(~Anode) <= 1) ? 32'd1 : 32'd0, 32'd1);
      assert ($countones(~Anode) <= 1) else $error("anode has multiple low bits");
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
    digits = d; enable = e; dp_in = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt, n_fe, n_fb, n_oth;
    logic [7:0] dis_fe, dis_fb;
    logic fd_last;

    // Reset, then load the scan-order pattern in the first FETCH cycle.
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    digits = 32'h76543210; enable = 8'hFF; dp_in = 8'h00; load = 1'b1;
    @(negedge clk);
    chk("reset_anode", {24'h0, Anode}, 32'hFF);
    chk("reset_display", {24'h0, display}, 32'hFF);
    chk("reset_frame_done", {31'h0, frame_done}, 32'h0);
    @(posedge clk); #2;
    load = 1'b0;

    // First frame shows the cleared active set; loaded data shows next frame.
    wait_fd();
    @(negedge clk);
    chk("fd_single_pulse", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    chk("digit0_anode", {24'h0, Anode}, 32'hFE);
    chk("digit0_display", {24'h0, display}, 32'hC0);
    repeat (4) @(negedge clk);
    chk("blank_after_d0", {24'h0, Anode}, 32'hFF);
    repeat (2) @(negedge clk);
    chk("digit1_anode", {24'h0, Anode}, 32'hFD);
    chk("digit1_display", {24'h0, display}, 32'hF9);
    wait_fd();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_done) break;
    end
    chk("frame_period", cnt, FRAME);

    // Enable mask and decimal point.
    tick();
    do_load(32'h000000F8, 8'h05, 8'h01);
    wait_fd();
    n_fe = 0; n_fb = 0; n_oth = 0; dis_fe = '0; dis_fb = '0; fd_last = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (Anode == 8'hFE) begin n_fe++; dis_fe = display; end
      else if (Anode == 8'hFB) begin n_fb++; dis_fb = display; end
      else if (Anode != 8'hFF) n_oth++;
      if (i == FRAME - 1) fd_last = frame_done;
    end
    chk("mask_fe_cycles", n_fe, 4);
    chk("mask_fb_cycles", n_fb, 4);
    chk("mask_other_low", n_oth, 0);
    chk("mask_fe_display", {24'h0, dis_fe}, 32'h00);
    chk("mask_fb_display", {24'h0, dis_fb}, 32'hC0);
    chk("mask_frame_end", {31'h0, fd_last}, 32'h1);

    // Mid-frame load takes effect only from the next frame.
    repeat (10) tick();
    do_load(32'h88888888, 8'hFF, 8'h00);
    wait_fd();
    repeat (2) @(negedge clk);
    chk("tearfree_d0_display", {24'h0, display}, 32'h80);

    // Load during the FETCH of digit 0 shows one frame later.
    wait_fd();
    tick();
    do_load(32'h11111111, 8'hFF, 8'h00);
    @(negedge clk);
    chk("fetch_load_deferred", {24'h0, display}, 32'h80);
    wait_fd();
    repeat (2) @(negedge clk);
    chk("fetch_load_applied_an", {24'h0, Anode}, 32'hFE);
    chk("fetch_load_applied_dis", {24'h0, display}, 32'hF9);

    // Reset during ON of digit 3.
    cnt = 0;
    while (Anode != 8'hF7 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("found_digit3", {24'h0, Anode}, 32'hF7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midon_reset_anode", {24'h0, Anode}, 32'hFF);
    chk("midon_reset_display", {24'h0, display}, 32'hFF);
    n_oth = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (Anode != 8'hFF) n_oth++;
    end
    chk("active_cleared_dark", n_oth, 0);

    // Random loads over ten frames; the compare process checks every cycle.
    do_load($urandom, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(15) == 0) begin
        do_load($urandom, 8'($urandom), 8'($urandom));
      end else begin
        tick();
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
